// File: rtl/program_loader_pkg.sv
// Shared types and default sizing for the program RAM loader.
package program_loader_pkg;
    localparam int DEF_RAM_BYTES = 16;
    localparam int DEF_ADDR_W    = 4;

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR} state_t;
endpackage

// File: rtl/program_loader_if.sv
// Host pin bundle plus RAM write port and status of the program loader.
interface program_loader_if #(parameter int ADDR_W = 4);
    logic              load_en_in;
    logic              strb_in;
    logic [7:0]        data_in;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              cpu_hold;
    logic              busy;
    logic              err;
    logic [ADDR_W:0]   byte_cnt;

    modport master (
        output load_en_in, strb_in, data_in,
        input  ram_we, ram_addr, ram_data, cpu_hold, busy, err, byte_cnt
    );
    modport slave (
        input  load_en_in, strb_in, data_in,
        output ram_we, ram_addr, ram_data, cpu_hold, busy, err, byte_cnt
    );
endinterface

// File: rtl/program_loader_sync_edge.sv
// Multi-flop pin synchronizer with registered level and one-cycle rise/fall pulses.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;

    // lvl is aligned with the pulses: lvl is already 1 when rise fires, 0 when fall fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            lvl  <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~lvl;
            fall <= ~sync[STAGES-1] & lvl;
        end
    end
endmodule

// File: rtl/program_loader.sv
// Writes a host-supplied program into the CPU RAM and holds the CPU until a valid image exists.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int RAM_BYTES    = DEF_RAM_BYTES,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int SYNC_STAGES  = 2,
    parameter int USE_CHECKSUM = 1
) (
    input logic             clk,
    input logic             rst,
    program_loader_if.slave bus
);
    localparam logic [ADDR_W:0] FULL = RAM_BYTES[ADDR_W:0];

    state_t          state;
    logic            prog_valid;
    logic [7:0]      csum;
    logic [ADDR_W:0] cnt_nxt;
    logic            le_lvl, le_rise, le_fall;
    logic            st_lvl, st_rise, st_fall;
    logic            unused_sync;

    sync_edge #(.STAGES(SYNC_STAGES)) u_le (
        .clk(clk), .rst(rst), .d(bus.load_en_in), .lvl(le_lvl), .rise(le_rise), .fall(le_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_st (
        .clk(clk), .rst(rst), .d(bus.strb_in), .lvl(st_lvl), .rise(st_rise), .fall(st_fall)
    );

    // Load-mode exits test the synced level, so a fall landing during WRITE is not lost.
    assign unused_sync = ^{le_fall, st_lvl, st_fall};
    assign cnt_nxt     = bus.byte_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            prog_valid   <= 1'b1;
            csum         <= '0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_data <= '0;
            bus.cpu_hold <= 1'b0;
            bus.busy     <= 1'b0;
            bus.err      <= 1'b0;
            bus.byte_cnt <= '0;
        end else begin
            bus.ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (le_rise) begin
                        state        <= LOAD;
                        bus.byte_cnt <= '0;
                        csum         <= '0;
                        bus.err      <= 1'b0;
                        prog_valid   <= 1'b0;
                        bus.cpu_hold <= 1'b1;
                        bus.busy     <= 1'b1;
                    end else begin
                        bus.cpu_hold <= !prog_valid;
                    end
                end
                LOAD: begin
                    if (!le_lvl) begin
                        state    <= ERROR;
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                    end else if (st_rise) begin
                        if (bus.byte_cnt < FULL) begin
                            state        <= WRITE;
                            bus.ram_we   <= 1'b1;
                            bus.ram_addr <= bus.byte_cnt[ADDR_W-1:0];
                            bus.ram_data <= bus.data_in;
                        end else if (USE_CHECKSUM != 0) begin
                            bus.busy <= 1'b0;
                            if (bus.data_in == csum) begin
                                state <= DONE;
                            end else begin
                                state   <= ERROR;
                                bus.err <= 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    // ram_data still holds the byte being written this cycle.
                    csum         <= csum ^ bus.ram_data;
                    bus.byte_cnt <= cnt_nxt;
                    if (USE_CHECKSUM == 0 && cnt_nxt == FULL) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end else begin
                        state <= LOAD;
                    end
                end
                DONE: begin
                    if (!le_lvl) begin
                        state        <= IDLE;
                        prog_valid   <= 1'b1;
                        bus.cpu_hold <= 1'b0;
                    end
                end
                ERROR: begin
                    if (!le_lvl) begin
                        state      <= IDLE;
                        prog_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Drives a checksum and a no-checksum loader from the same host pins and checks both.
module tb_program_loader;
    localparam int S   = 2;
    localparam int RB  = 16;
    localparam int LAT = S + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_en = 1'b0;
    logic       strb = 1'b0;
    logic [7:0] data = 8'h00;
    longint     cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    program_loader_if #(.ADDR_W(4)) ifa ();
    program_loader_if #(.ADDR_W(4)) ifb ();
    assign ifa.load_en_in = load_en;
    assign ifa.strb_in    = strb;
    assign ifa.data_in    = data;
    assign ifb.load_en_in = load_en;
    assign ifb.strb_in    = strb;
    assign ifb.data_in    = data;

    program_loader #(.RAM_BYTES(RB), .ADDR_W(4), .SYNC_STAGES(S), .USE_CHECKSUM(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    program_loader #(.RAM_BYTES(RB), .ADDR_W(4), .SYNC_STAGES(S), .USE_CHECKSUM(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    // Reference model, one entry per DUT (0: checksum, 1: no checksum).
    // m_st: 0 idle, 1 accepting bytes, 2 finished ok, 3 failed.
    typedef struct {logic [3:0] a; logic [7:0] d; longint due;} wr_t;
    wr_t        qa[$];
    wr_t        qb[$];
    int         m_st[2];
    int         m_cnt[2];
    logic [7:0] m_cs[2];
    logic       m_err[2];
    logic       m_valid[2];

    typedef struct {
        int nb; bit send_cs; logic [7:0] bad; bit extra; bit simul; logic [7:0] base;
        bit ea; int ca; bit eb; int cb;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < 2; c++) begin
            m_st[c] = 0; m_cnt[c] = 0; m_cs[c] = 8'h00; m_err[c] = 1'b0; m_valid[c] = 1'b1;
        end
        qa.delete();
        qb.delete();
    endfunction

    function automatic void m_start();
        for (int c = 0; c < 2; c++) begin
            m_st[c] = 1; m_cnt[c] = 0; m_cs[c] = 8'h00; m_err[c] = 1'b0; m_valid[c] = 1'b0;
        end
    endfunction

    function automatic void m_fall();
        for (int c = 0; c < 2; c++) begin
            if (m_st[c] == 1) begin m_err[c] = 1'b1; m_valid[c] = 1'b0; end
            else if (m_st[c] == 2) m_valid[c] = 1'b1;
            m_st[c] = 0;
        end
    endfunction

    function automatic void m_strobe(input logic [7:0] b, input longint t);
        wr_t w;
        for (int c = 0; c < 2; c++) begin
            if (m_st[c] != 1) continue;
            if (m_cnt[c] < RB) begin
                w.a = 4'(m_cnt[c]); w.d = b; w.due = t + LAT;
                if (c == 0) qa.push_back(w); else qb.push_back(w);
                m_cs[c] ^= b;
                m_cnt[c]++;
                if (c == 1 && m_cnt[c] == RB) m_st[c] = 2;
            end else if (c == 0) begin
                if (b == m_cs[c]) m_st[c] = 2;
                else begin m_st[c] = 3; m_err[c] = 1'b1; end
            end
        end
    endfunction

    task automatic mon(input int c, input logic [3:0] a, input logic [7:0] d);
        wr_t   w;
        string nm;
        nm = (c == 0) ? "wr_a" : "wr_b";
        if ((c == 0 && qa.size() == 0) || (c == 1 && qb.size() == 0)) begin
            checks++; errors++;
            $display("FAIL %s unexpected ram_we actual addr=%0h data=%0h required none", nm, a, d);
            return;
        end
        if (c == 0) w = qa.pop_front(); else w = qb.pop_front();
        chk({nm, "_addr"}, 32'(a), 32'(w.a));
        chk({nm, "_data"}, 32'(d), 32'(w.d));
        chk({nm, "_cycle"}, 32'(cyc), 32'(w.due));
    endtask

    always @(negedge clk) begin
        if (ifa.ram_we === 1'b1) mon(0, ifa.ram_addr, ifa.ram_data);
        if (ifb.ram_we === 1'b1) mon(1, ifb.ram_addr, ifb.ram_data);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        data = b; strb = 1'b1;
        m_strobe(b, cyc);
        tick(6);
        strb = 1'b0;
        tick(6);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_a"}, 32'({ifa.ram_we, ifa.ram_addr, ifa.ram_data, ifa.cpu_hold,
                             ifa.busy, ifa.err, ifa.byte_cnt}), 32'd0);
        chk({nm, "_b"}, 32'({ifb.ram_we, ifb.ram_addr, ifb.ram_data, ifb.cpu_hold,
                             ifb.busy, ifb.err, ifb.byte_cnt}), 32'd0);
    endtask

    task automatic check_idle(input string t, input bit ea, input int ca, input bit eb, input int cb);
        chk({t, "_err_a"},  32'(ifa.err),      32'(ea));
        chk({t, "_cnt_a"},  32'(ifa.byte_cnt), 32'(ca));
        chk({t, "_hold_a"}, 32'(ifa.cpu_hold), 32'(ea));
        chk({t, "_busy_a"}, 32'(ifa.busy),     32'd0);
        chk({t, "_err_b"},  32'(ifb.err),      32'(eb));
        chk({t, "_cnt_b"},  32'(ifb.byte_cnt), 32'(cb));
        chk({t, "_hold_b"}, 32'(ifb.cpu_hold), 32'(eb));
        chk({t, "_busy_b"}, 32'(ifb.busy),     32'd0);
    endtask

    // One complete load; leaves load_en low and the DUTs settled in IDLE.
    task automatic run_load(input string t, input vec_t v, input bit rnd);
        load_en = 1'b1;
        m_start();
        tick(8);
        for (int i = 0; i < v.nb; i++) strobe(rnd ? 8'($urandom) : v.base + 8'(i));
        if (v.send_cs) strobe(m_cs[0] ^ v.bad);
        if (v.extra) strobe(8'h55);
        chk({t, "_busy_pre_a"}, 32'(ifa.busy), 32'(m_st[0] == 1));
        chk({t, "_busy_pre_b"}, 32'(ifb.busy), 32'(m_st[1] == 1));
        chk({t, "_hold_pre_a"}, 32'(ifa.cpu_hold), 32'd1);
        chk({t, "_hold_pre_b"}, 32'(ifb.cpu_hold), 32'd1);
        if (v.simul) begin
            data = 8'h77; strb = 1'b1; load_en = 1'b0;
            m_fall();
            tick(6);
            strb = 1'b0;
        end else begin
            load_en = 1'b0;
            m_fall();
        end
        tick(10);
    endtask

    initial begin
        vec_t v;
        int   rel_a, rel_b;
        tbl = '{
            '{16, 1'b1, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 16, 1'b0, 16},
            '{16, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h10, 1'b1, 16, 1'b0, 16},
            '{ 5, 1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 1'b1,  5, 1'b1,  5},
            '{16, 1'b1, 8'h00, 1'b0, 1'b0, 8'h40, 1'b0, 16, 1'b0, 16},
            '{ 3, 1'b0, 8'h00, 1'b0, 1'b1, 8'h50, 1'b1,  3, 1'b1,  3},
            '{16, 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 1'b1, 16, 1'b0, 16},
            '{16, 1'b0, 8'h00, 1'b0, 1'b0, 8'h60, 1'b1, 16, 1'b0, 16},
            '{ 0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1,  0, 1'b1,  0}
        };
        m_reset();
        #2 rst = 1'b1;
        #1 check_zero("reset_outs");
        tick(3);
        rst = 1'b0;
        tick(3);
        check_zero("post_reset_outs");

        for (int i = 0; i < 8; i++) begin
            run_load($sformatf("vec%0d", i), tbl[i], 1'b0);
            check_idle($sformatf("vec%0d", i), tbl[i].ea, tbl[i].ca, tbl[i].eb, tbl[i].cb);
        end

        for (int r = 0; r < 14; r++) begin
            v.nb      = $urandom_range(0, RB);
            v.send_cs = 1'($urandom_range(0, 1));
            v.bad     = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            v.extra   = 1'($urandom_range(0, 1));
            v.simul   = 1'($urandom_range(0, 1));
            v.base    = 8'h00;
            run_load($sformatf("rnd%0d", r), v, 1'b1);
            check_idle($sformatf("rnd%0d", r), m_err[0], m_cnt[0], m_err[1], m_cnt[1]);
        end

        // cpu_hold must still be set as load_en drops, and release within a bounded window.
        load_en = 1'b1; m_start(); tick(8);
        for (int i = 0; i < RB; i++) strobe(8'h10 + 8'(i));
        strobe(m_cs[0]);
        load_en = 1'b0; m_fall();
        chk("hold_at_fall_a", 32'(ifa.cpu_hold), 32'd1);
        chk("hold_at_fall_b", 32'(ifb.cpu_hold), 32'd1);
        rel_a = -1; rel_b = -1;
        for (int n = 1; n <= 2 * LAT; n++) begin
            tick(1);
            if (rel_a < 0 && ifa.cpu_hold === 1'b0) rel_a = n;
            if (rel_b < 0 && ifb.cpu_hold === 1'b0) rel_b = n;
        end
        chk("hold_release_a", 32'(rel_a > 0), 32'd1);
        chk("hold_release_b", 32'(rel_b > 0), 32'd1);
        tick(4);

        // Reset in the middle of a load clears every output at once.
        load_en = 1'b1; m_start(); tick(8);
        for (int i = 0; i < 3; i++) strobe(8'hC0 + 8'(i));
        rst = 1'b1;
        #1 check_zero("midload_reset_outs");
        m_reset();
        load_en = 1'b0; strb = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        check_zero("midload_after_release");
        run_load("recover", tbl[0], 1'b0);
        check_idle("recover", tbl[0].ea, tbl[0].ca, tbl[0].eb, tbl[0].cb);

        chk("pending_writes_a", 32'(qa.size()), 32'd0);
        chk("pending_writes_b", 32'(qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
